// File: rtl/ascii_word_assembler_pkg.sv
// Shared constants and FSM state type for the ASCII word assembler.
// The downstream ASCII-to-BCD converter reuses ASCII_ZERO as its pad digit.
package ascii_word_assembler_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  // Width of out_len; holds 0..CHARS for the default 4-character word.
  localparam int LEN_W = 3;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/ascii_word_assembler.sv
// Packs a serial stream of ASCII characters into one word, first character in the MSB byte.
// The word is released early on a terminator; unused leading bytes keep the pad character.
module ascii_word_assembler
  import ascii_word_assembler_pkg::*;
#(
  parameter int                N         = 32,
  parameter int                CHAR_W    = 8,
  parameter int                CHARS     = N / CHAR_W,
  parameter logic [CHAR_W-1:0] PAD_CHAR  = ASCII_ZERO,
  parameter logic [CHAR_W-1:0] TERM_CHAR = ASCII_CR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_char,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_word,
  output logic [LEN_W-1:0]  out_len
);

  localparam logic [N-1:0]     PAD_WORD = {CHARS{PAD_CHAR}};
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(CHARS);

  state_e           state_q, state_d;
  logic [N-1:0]     word_q, word_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_plus;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      word_q  <= PAD_WORD;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
    end
  end

  assign len_plus = len_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    len_d     = len_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        // in_ready must drop the moment rst_n asserts, not one edge later.
        in_ready = rst_n;
        accept   = in_valid && rst_n;
        if (accept) begin
          if (in_char == TERM_CHAR) begin
            // A terminator on an empty word is swallowed without producing output.
            if (len_q != '0) begin
              state_d = ST_HOLD;
            end
          end else begin
            word_d = {word_q[N-CHAR_W-1:0], in_char};
            len_d  = len_plus;
            if (len_plus == FULL_LEN) begin
              state_d = ST_HOLD;
            end
          end
        end
      end

      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_COLLECT;
          word_d  = PAD_WORD;
          len_d   = '0;
        end
      end
    endcase
  end

  assign out_word = word_q;
  assign out_len  = len_q;

endmodule

// File: tb/tb_ascii_word_assembler.sv
// Directed plus randomized bench for ascii_word_assembler against a queue-based model
// that places received characters into the word by byte position.
module tb_ascii_word_assembler;

  localparam logic [7:0]  CR  = 8'h0D;
  localparam logic [31:0] PAD = 32'h30303030;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [2:0]  out_len;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mq[$];

  ascii_word_assembler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_len   (out_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Real characters occupy the low bytes in arrival order; everything above stays pad.
  function automatic logic [31:0] model_word();
    logic [31:0] w;
    int n;
    w = PAD;
    n = mq.size();
    for (int i = 0; i < n; i++) w[8*(n-1-i) +: 8] = mq[i];
    return w;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_char(input logic [7:0] c);
    int budget;
    budget = 0;
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [2:0] l, input int hold,
                             input bit offer_en, input logic [7:0] offer);
    if (offer_en) begin
      in_valid = 1'b1;
      in_char  = offer;
    end
    out_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_word", out_word, w);
      check("hold_len", {29'b0, out_len}, {29'b0, l});
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("word_valid", {31'b0, out_valid}, 32'd1);
    check("word_value", out_word, w);
    check("word_len", {29'b0, out_len}, {29'b0, l});
    check("word_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("post_valid", {31'b0, out_valid}, 32'd0);
    check("post_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_word", out_word, PAD);
    check("post_len", {29'b0, out_len}, 32'd0);
    if (offer_en) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      mq.push_back(offer);
      check("offer_len", {29'b0, out_len}, 32'd1);
      check("offer_word", out_word, model_word());
    end
  endtask

  task automatic flush_model(input int hold);
    logic [31:0] w;
    logic [2:0]  l;
    w = model_word();
    l = 3'(mq.size());
    mq.delete();
    expect_word(w, l, hold, 1'b0, 8'h00);
  endtask

  task automatic push_char(input logic [7:0] c, input int hold);
    send_char(c);
    if (c == CR) begin
      if (mq.size() == 0) begin
        check("empty_term_valid", {31'b0, out_valid}, 32'd0);
        check("empty_term_ready", {31'b0, in_ready}, 32'd1);
        check("empty_term_len", {29'b0, out_len}, 32'd0);
      end else begin
        flush_model(hold);
      end
    end else begin
      mq.push_back(c);
      if (mq.size() == 4) begin
        flush_model(hold);
      end else begin
        check("partial_valid", {31'b0, out_valid}, 32'd0);
        check("partial_ready", {31'b0, in_ready}, 32'd1);
        check("partial_len", {29'b0, out_len}, mq.size());
        check("partial_word", out_word, model_word());
      end
    end
  endtask

  initial begin
    logic [7:0] c;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;

    // Reset values, then release
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_word", out_word, PAD);
    check("rst_out_len", {29'b0, out_len}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Full word, back-to-back, out_ready held high
    push_char("1", 0);
    push_char("2", 0);
    push_char("3", 0);
    send_char("4");
    mq.delete();
    expect_word(32'h31323334, 3'd4, 0, 1'b0, 8'h00);

    // Early flush on CR
    push_char("7", 0);
    push_char("8", 0);
    send_char(CR);
    mq.delete();
    expect_word(32'h30303738, 3'd2, 0, 1'b0, 8'h00);

    // Lone terminator is dropped, then a full word of '8'
    push_char(CR, 0);
    push_char("8", 0);
    push_char("8", 0);
    push_char("8", 0);
    send_char("8");
    mq.delete();
    expect_word(32'h38383838, 3'd4, 0, 1'b0, 8'h00);

    // Backpressure with a fifth character offered while the word is held
    push_char("s", 0);
    push_char("s", 0);
    push_char("s", 0);
    send_char("s");
    mq.delete();
    expect_word(32'h73737373, 3'd4, 5, 1'b1, "x");
    push_char("y", 0);
    push_char(CR, 2);

    // Asynchronous reset in the middle of a word
    push_char("5", 0);
    push_char("6", 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_word", out_word, PAD);
    check("mid_rst_len", {29'b0, out_len}, 32'd0);
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    push_char("9", 0);
    push_char("9", 0);
    push_char("9", 0);
    send_char("9");
    mq.delete();
    expect_word(32'h39393939, 3'd4, 0, 1'b0, 8'h00);

    // Randomized characters, terminators, backpressure and idle gaps
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 5) == 0) c = CR;
      else c = 8'($urandom_range(0, 255));
      push_char(c, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
